// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational float16 FPU among N_REQ requesters.
// Optional saturating statistics counters are enabled with `define FPU_SCHED_STATS_EN.
module fpu_rr_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned FPU_LAT = 1,
  parameter int unsigned ID_W    = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*16-1:0]  req_a,
  input  logic [N_REQ*16-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_op,
  output logic [15:0]          fpu_a,
  output logic [15:0]          fpu_b,
  output logic                 fpu_op,
  input  logic [15:0]          fpu_result,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_data,
  input  logic                 flush,
  output logic                 flush_done,
`ifdef FPU_SCHED_STATS_EN
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall,
`endif
  output logic                 busy
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_id;
  logic                found;
  logic                grant_en;
  logic [N_REQ-1:0]    gnt;
  logic                hs;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic                sel_op;
  int unsigned         idx;

  // Tag stage aligned with the registered operands, then FPU_LAT result stages
  logic [N_REQ-1:0]    t0_oh;
  logic [ID_W-1:0]     t0_id;
  logic [N_REQ-1:0]    p_oh   [FPU_LAT];
  logic [ID_W-1:0]     p_id   [FPU_LAT];
  logic [DATA_W-1:0]   p_data [FPU_LAT];

  logic                pipe_any;
  logic                pipe_next_any;
  logic                flush_done_d;
  logic                busy_d;

  assign grant_en = !rst && !flush && (state != DRAIN);

  // Rotating priority search starting just after the last granted requester
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    gnt    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && (i == idx) && req_valid[i]) begin
          found  = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt[i] = grant_en && found && (ID_W'(i) == gnt_id);
    end
  end

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
        sel_op = req_op[i];
      end
    end
  end

  // pipe_next_any looks one cycle ahead: the oldest stage shifts out
  always_comb begin
    pipe_any      = |t0_oh;
    pipe_next_any = hs | (|t0_oh);
    for (int unsigned k = 0; k < FPU_LAT; k++) begin
      pipe_any = pipe_any | (|p_oh[k]);
      if (k + 1 < FPU_LAT) begin
        pipe_next_any = pipe_next_any | (|p_oh[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d      = state;
    flush_done_d = 1'b0;
    busy_d       = 1'b0;
    case (state)
      IDLE: begin
        if (flush)   state_d = DRAIN;
        else if (hs) state_d = RUN;
      end
      RUN: begin
        if (flush)                 state_d = DRAIN;
        else if (!hs && !pipe_any) state_d = IDLE;
      end
      DRAIN: begin
        if (!pipe_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush_done lands in the DRAIN cycle that first sees an empty pipeline
    flush_done_d = (state_d == DRAIN) && !pipe_next_any;
    busy_d       = (state_d != IDLE) || pipe_next_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= ID_W'(N_REQ - 1);
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= 1'b0;
      t0_oh      <= '0;
      t0_id      <= '0;
      flush_done <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned k = 0; k < FPU_LAT; k++) begin
        p_oh[k]   <= '0;
        p_id[k]   <= '0;
        p_data[k] <= '0;
      end
    end else begin
      if (hs) begin
        rr_ptr <= gnt_id;
        fpu_a  <= sel_a;
        fpu_b  <= sel_b;
        fpu_op <= sel_op;
      end
      t0_oh     <= gnt;
      t0_id     <= gnt_id;
      p_oh[0]   <= t0_oh;
      p_id[0]   <= t0_id;
      p_data[0] <= fpu_result;
      for (int unsigned k = 1; k < FPU_LAT; k++) begin
        p_oh[k]   <= p_oh[k-1];
        p_id[k]   <= p_id[k-1];
        p_data[k] <= p_data[k-1];
      end
      flush_done <= flush_done_d;
      busy       <= busy_d;
    end
  end

  assign rsp_valid = p_oh[FPU_LAT-1];
  assign rsp_id    = p_id[FPU_LAT-1];
  assign rsp_data  = p_data[FPU_LAT-1];

`ifdef FPU_SCHED_STATS_EN
  // Saturating handshake and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (hs && (stat_ops != 32'hFFFF_FFFF))
        stat_ops <= stat_ops + 32'd1;
      if ((|req_valid) && !hs && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler: one DUT with FPU_LAT=1 and one with FPU_LAT=3 on shared stimulus.
module tb_fpu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_op;
  logic        flush;

  logic [3:0]  ready1, rv1, ready3, rv3;
  logic [15:0] fa1, fb1, fr1, rd1, fa3, fb3, fr3, rd3;
  logic        fo1, fd1, busy1, fo3, fd3, busy3;
  logic [1:0]  rid1, rid3;
`ifdef FPU_SCHED_STATS_EN
  logic [31:0] sops1, sstall1, sops3, sstall3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared FPU; the scheduler only transports its result
  function automatic logic [15:0] fpu_stub(input logic [15:0] a, input logic [15:0] b, input logic op);
    return op ? (a ^ {b[7:0], b[15:8]}) : (a + b);
  endfunction

  function automatic logic [15:0] lane_a(input int i);
    return 16'h3C00 + 16'(i * 'h111);
  endfunction

  function automatic logic [15:0] lane_b(input int i);
    return 16'h4000 + 16'(i * 3);
  endfunction

  assign fr1 = fpu_stub(fa1, fb1, fo1);
  assign fr3 = fpu_stub(fa3, fb3, fo3);

  fpu_rr_scheduler #(.N_REQ(4), .FPU_LAT(1), .ID_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fa1), .fpu_b(fb1), .fpu_op(fo1), .fpu_result(fr1),
    .rsp_valid(rv1), .rsp_id(rid1), .rsp_data(rd1),
    .flush(flush), .flush_done(fd1),
`ifdef FPU_SCHED_STATS_EN
    .stat_ops(sops1), .stat_stall(sstall1),
`endif
    .busy(busy1)
  );

  fpu_rr_scheduler #(.N_REQ(4), .FPU_LAT(3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_a(fa3), .fpu_b(fb3), .fpu_op(fo3), .fpu_result(fr3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_data(rd3),
    .flush(flush), .flush_done(fd3),
`ifdef FPU_SCHED_STATS_EN
    .stat_ops(sops3), .stat_stall(sstall3),
`endif
    .busy(busy3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] ops);
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = lane_a(i);
      req_b[16*i +: 16] = lane_b(i);
    end
    req_op = ops;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    n_vec++;
    if ({ready1, fa1, fb1, fo1, rv1, rid1, rd1, fd1, busy1} !== '0) begin
      n_err++;
      $display("FAIL reset_outs_lat1: got %h want 0", {ready1, fa1, fb1, fo1, rv1, rid1, rd1, fd1, busy1});
    end
    n_vec++;
    if ({ready3, fa3, fb3, fo3, rv3, rid3, rd3, fd3, busy3} !== '0) begin
      n_err++;
      $display("FAIL reset_outs_lat3: got %h want 0", {ready3, fa3, fb3, fo3, rv3, rid3, rd3, fd3, busy3});
    end
    tick;
  endtask

  task automatic test_single_add;
    apply_reset;
    req_a = '0; req_b = '0; req_op = '0;
    req_a[15:0] = 16'h3C00;
    req_b[15:0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (ready1 !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", ready1); end
    tick;
    req_valid = '0;
    #1;
    n_vec++;
    if ({fa1, fb1, fo1} !== {16'h3C00, 16'h4000, 1'b0}) begin
      n_err++;
      $display("FAIL single_operands: got %h %h %b want 3c00 4000 0", fa1, fb1, fo1);
    end
    tick;
    #1;
    n_vec++;
    if ({rv1, rid1, rd1} !== {4'b0001, 2'd0, fpu_stub(16'h3C00, 16'h4000, 1'b0)}) begin
      n_err++;
      $display("FAIL single_rsp: got %b %0d %h want 0001 0 %h", rv1, rid1, rd1, fpu_stub(16'h3C00, 16'h4000, 1'b0));
    end
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    int id;
    apply_reset;
    set_lanes(4'b1010);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        exp_oh = 4'b0001 << (c % 4);
        n_vec++;
        if (ready1 !== exp_oh || ready3 !== exp_oh) begin
          n_err++;
          $display("FAIL rr_grant c%0d: got %b/%b want %b", c, ready1, ready3, exp_oh);
        end
      end
      if (c >= 2) begin
        id = (c - 2) % 4;
        exp_oh = 4'b0001 << id;
        n_vec++;
        if (rv1 !== exp_oh || rid1 !== 2'(id) || rd1 !== fpu_stub(lane_a(id), lane_b(id), req_op[id])) begin
          n_err++;
          $display("FAIL rr_rsp c%0d: got %b %0d %h want %b %0d %h", c, rv1, rid1, rd1, exp_oh, id,
                   fpu_stub(lane_a(id), lane_b(id), req_op[id]));
        end
      end
      tick;
    end
  endtask

  task automatic test_wrap_skip;
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000;
    apply_reset;
    set_lanes(4'b0000);
    req_valid = 4'b0100;
    #1;
    n_vec++;
    if (ready1 !== 4'b0100) begin n_err++; $display("FAIL wrap_setup: got %b want 0100", ready1); end
    tick;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1010;
      #1;
      n_vec++;
      if (ready1 !== exp_seq[c]) begin
        n_err++;
        $display("FAIL wrap_grant c%0d: got %b want %b", c, ready1, exp_seq[c]);
      end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_flush_drain;
    apply_reset;
    set_lanes(4'b0100);
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 3) ? 4'b0111 : 4'b1111;
      flush = (c == 3 || c == 5);
      #1;
      n_vec++;
      if (c < 3) begin
        if (ready3 !== (4'b0001 << c)) begin n_err++; $display("FAIL flush_pre_grant c%0d: got %b want %b", c, ready3, 4'b0001 << c); end
      end else if (c < 8) begin
        if (ready3 !== 4'b0000) begin n_err++; $display("FAIL flush_no_grant c%0d: got %b want 0000", c, ready3); end
      end else begin
        if (ready3 !== 4'b1000) begin n_err++; $display("FAIL flush_after_grant: got %b want 1000", ready3); end
      end
      if (c >= 4 && c <= 6) begin
        n_vec++;
        if (rv3 !== (4'b0001 << (c - 4)) || rid3 !== 2'(c - 4) || rd3 !== fpu_stub(lane_a(c - 4), lane_b(c - 4), req_op[c - 4])) begin
          n_err++;
          $display("FAIL flush_rsp c%0d: got %b %0d %h want %b %0d", c, rv3, rid3, rd3, 4'b0001 << (c - 4), c - 4);
        end
      end
      if (c >= 3) begin
        n_vec++;
        if (fd3 !== (c == 7)) begin n_err++; $display("FAIL flush_done c%0d: got %b want %b", c, fd3, c == 7); end
      end
      if (c == 7 || c == 8) begin
        n_vec++;
        if (busy3 !== (c == 7)) begin n_err++; $display("FAIL flush_busy c%0d: got %b want %b", c, busy3, c == 7); end
      end
      tick;
    end
    req_valid = '0;
    flush = 1'b0;
  endtask

  task automatic test_flush_idle;
    apply_reset;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    n_vec++;
    if (fd1 !== 1'b1 || fd3 !== 1'b1) begin n_err++; $display("FAIL flush_idle_done: got %b/%b want 1/1", fd1, fd3); end
    tick;
    #1;
    n_vec++;
    if ({fd1, fd3, busy1, busy3} !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_idle_after: got %b want 0000", {fd1, fd3, busy1, busy3});
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    apply_reset;
    set_lanes(4'b0011);
    for (int c = 0; c < 2; c++) begin
      req_valid = 4'b0011;
      #1;
      n_vec++;
      if (ready1 !== (4'b0001 << c)) begin n_err++; $display("FAIL rstmid_grant c%0d: got %b want %b", c, ready1, 4'b0001 << c); end
      tick;
    end
    req_valid = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({ready1, fa1, fb1, fo1, rv1, rid1, rd1, fd1, busy1} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outs: got %h want 0", {ready1, fa1, fb1, fo1, rv1, rid1, rd1, fd1, busy1});
    end
    for (int c = 3; c < 7; c++) begin
      if (c > 3) begin
        req_valid = (c == 4) ? 4'hF : 4'h0;
        #1;
      end
      if (c == 4) begin
        n_vec++;
        if (ready1 !== 4'b0001) begin n_err++; $display("FAIL rstmid_next_grant: got %b want 0001", ready1); end
      end
      n_vec++;
      if (rv3 !== 4'b0000 || (c < 6 && rv1 !== 4'b0000)) begin
        n_err++;
        $display("FAIL rstmid_no_rsp c%0d: got %b/%b want 0000", c, rv1, rv3);
      end
      tick;
    end
    req_valid = '0;
  endtask

`ifdef FPU_SCHED_STATS_EN
  task automatic test_stats;
    apply_reset;
    set_lanes(4'b0000);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 7) ? 4'hF : 4'h0;
      flush = (c == 5);
      tick;
    end
    flush = 1'b0;
    #1;
    n_vec++;
    if (sops1 !== 32'd5 || sstall1 !== 32'd2) begin
      n_err++;
      $display("FAIL stats_lat1: got ops %0d stall %0d want 5 2", sops1, sstall1);
    end
    n_vec++;
    if (sops3 !== 32'd5 || sstall3 !== 32'd2) begin
      n_err++;
      $display("FAIL stats_lat3: got ops %0d stall %0d want 5 2", sops3, sstall3);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    flush = 1'b0;
    test_reset;
    test_single_add;
    test_round_robin;
    test_wrap_skip;
    test_flush_drain;
    test_flush_idle;
    test_reset_mid_op;
`ifdef FPU_SCHED_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
